// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory port between the CPU (C) and the loader/DMA (D).
// Registers the winning access onto the memory port and returns read data after a fixed latency.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);

   localparam logic [3:0] LAT = 4'(RD_LATENCY);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

   state_t     state, state_nx;
   logic       last_d;   // 1 = D owned the most recent grant (and owns any in-flight read)
   logic [3:0] cnt;
   logic       grant, pick_d;

   // On a tie, the port that did not win last time gets the grant.
   always_comb begin
      pick_d   = d_req & (~c_req | ~last_d);
      grant    = (state == IDLE) & (c_req | d_req) & ~reset;
      c_gnt    = grant & ~pick_d;
      d_gnt    = grant & pick_d;
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = ACCESS;
         ACCESS:  state_nx = m_we ? IDLE : WAIT;
         WAIT:    if (cnt == 4'd1) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last_d   <= 1'b1;
         cnt      <= '0;
         m_en     <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         c_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         c_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         state    <= state_nx;
         m_en     <= 1'b0;
         m_we     <= 1'b0;
         c_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  m_en    <= 1'b1;
                  m_we    <= pick_d ? d_we : c_we;
                  m_addr  <= pick_d ? d_addr : c_addr;
                  m_wdata <= pick_d ? d_wdata : c_wdata;
                  last_d  <= pick_d;
               end
            end
            ACCESS: begin
               if (!m_we) cnt <= LAT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  if (last_d) begin
                     d_rdata  <= m_rdata;
                     d_rvalid <= 1'b1;
                  end else begin
                     c_rdata  <= m_rdata;
                     c_rvalid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected read returns,
// a monitor pops and checks them on every rvalid pulse.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
   logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
   logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
   logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   // second instance built with RD_LATENCY=1
   logic        c_req2 = 0;
   logic [31:0] c_addr2 = 32'h20;
   logic        zero1 = 1'b0;
   logic [31:0] zero32 = '0;
   logic        c_gnt2, c_rvalid2, d_gnt2, d_rvalid2, m_en2, m_we2, busy2;
   logic [31:0] c_rdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;

   int tests = 0, fails = 0, cyc = 0;

   typedef struct { bit port; logic [31:0] data; int cyc; } exp_t;
   exp_t sb[$];

   logic [31:0] mem [0:63];
   logic [31:0] pipe0, pipe1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy));

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LATENCY(1)) dut2 (
      .clk(clk), .reset(reset),
      .c_req(c_req2), .c_we(zero1), .c_addr(c_addr2), .c_wdata(zero32),
      .c_gnt(c_gnt2), .c_rvalid(c_rvalid2), .c_rdata(c_rdata2),
      .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
      .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
      .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2),
      .m_rdata(m_rdata2), .busy(busy2));

   // Latency-2 memory: data sampled on the m_en edge appears two cycles later; poison otherwise.
   always @(posedge clk) begin
      if (reset) mem[4] <= 32'hDEADBEEF;
      else if (m_en && m_we) mem[m_addr[7:2]] <= m_wdata;
      pipe0 <= (m_en && !m_we) ? mem[m_addr[7:2]] : 32'hBAD0BAD0;
      pipe1 <= pipe0;
   end
   assign m_rdata = pipe1;

   always @(posedge clk)
      m_rdata2 <= (m_en2 && !m_we2) ? (m_addr2 ^ 32'hC0DE0000) : 32'hBAD1BAD1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rvalid pulse must match the oldest expected return.
   always @(negedge clk) begin
      if (!reset) begin
         if (m_we) chk("m_we_without_m_en", {31'd0, m_en}, 32'd1);
         if (c_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rvalid_port", {30'd0, c_rvalid, d_rvalid}, e.port ? 32'd1 : 32'd2);
               chk("rdata", e.port ? d_rdata : c_rdata, e.data);
               chk("rvalid_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_c_gnt"}, {31'd0, c_gnt}, 0);
      chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 0);
      chk({tag, "_rvalid"}, {30'd0, c_rvalid, d_rvalid}, 0);
      chk({tag, "_c_rdata"}, c_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_m_en_we"}, {30'd0, m_en, m_we}, 0);
      chk({tag, "_m_addr"}, m_addr, 0);
      chk({tag, "_m_wdata"}, m_wdata, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
   endtask

   // Called at a negedge; returns at #1 after the edge following the grant.
   task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp,
                         output int g, output int waited);
      if (port) begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1; end
      else      begin c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1; end
      waited = -1;
      g = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (port ? d_gnt : c_gnt) begin g = cyc; waited = i; break; end
         @(negedge clk);
      end
      if (waited < 0) chk("gnt_timeout", 0, 1);
      else if (!we) sb.push_back('{port: port, data: exp, cyc: g + 4});
      @(posedge clk); #1;
      if (port) d_req = 0; else c_req = 0;
   endtask

   initial begin
      int g, w, n;
      bit exp_order [4] = '{0, 1, 0, 1};

      // Reset state
      @(negedge clk); #1;
      chk_zero("reset");
      @(negedge clk); reset = 0;

      // 1: CPU read of 0x10
      @(negedge clk);
      do_req(0, 0, 32'h10, 0, 32'hDEADBEEF, g, w);
      chk("t1_gnt_wait", w, 0);
      @(negedge clk);
      chk("t1_m_en", {30'd0, m_en, m_we}, 32'd2);
      chk("t1_m_addr", m_addr, 32'h10);
      repeat (4) @(negedge clk);

      // 2: loader write 0x40 <- 0x1234, then read back
      do_req(1, 1, 32'h40, 32'h1234, 0, g, w);
      @(negedge clk);
      chk("t2_m_en_we", {30'd0, m_en, m_we}, 32'd3);
      chk("t2_m_addr", m_addr, 32'h40);
      chk("t2_m_wdata", m_wdata, 32'h1234);
      @(negedge clk);
      chk("t2_busy_T2", {31'd0, busy}, 0);
      do_req(1, 0, 32'h40, 0, 32'h1234, g, w);
      chk("t2_rd_gnt_wait", w, 0);
      repeat (6) @(negedge clk);
      chk("t2_sb_empty", sb.size(), 0);

      // 3: both ports requesting from reset -> C, D, C, D
      @(negedge clk);
      reset = 1;
      c_we = 0; c_addr = 32'h10; d_we = 0; d_addr = 32'h40;
      c_req = 1; d_req = 1;
      @(negedge clk); reset = 0;
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         #1;
         chk("t3_not_both", {30'd0, c_gnt, d_gnt} == 2'b11, 0);
         if (c_gnt || d_gnt) begin
            chk("t3_order", {31'd0, d_gnt}, {31'd0, exp_order[n]});
            sb.push_back('{port: d_gnt, data: d_gnt ? 32'h1234 : 32'hDEADBEEF, cyc: cyc + 4});
            n++;
         end
         if (n < 4) @(negedge clk);
      end
      chk("t3_grant_count", n, 4);
      @(posedge clk); #1;
      c_req = 0; d_req = 0;
      repeat (6) @(negedge clk);
      chk("t3_sb_empty", sb.size(), 0);

      // 4: loader write raised during CPU read WAIT
      do_req(0, 0, 32'h10, 0, 32'hDEADBEEF, g, w);
      @(negedge clk);
      @(negedge clk);
      d_we = 1; d_addr = 32'h80; d_wdata = 32'hA5A5; d_req = 1;
      #1;
      chk("t4_no_gnt_w1", {31'd0, d_gnt}, 0);
      chk("t4_m_en_w1", {31'd0, m_en}, 0);
      @(negedge clk); #1;
      chk("t4_no_gnt_w2", {31'd0, d_gnt}, 0);
      chk("t4_m_en_w2", {31'd0, m_en}, 0);
      @(negedge clk); #1;
      chk("t4_gnt_with_rvalid", {30'd0, d_gnt, c_rvalid}, 32'd3);
      @(posedge clk); #1;
      d_req = 0;
      repeat (4) @(negedge clk);

      // 5: reset asserted during WAIT discards the read
      do_req(0, 0, 32'h80, 0, 32'hA5A5, g, w);
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      #1;
      chk_zero("t5_reset");
      sb.delete();
      @(negedge clk); reset = 0;
      repeat (8) @(negedge clk);
      do_req(0, 0, 32'h80, 0, 32'hA5A5, g, w);
      chk("t5_gnt_wait", w, 0);
      repeat (6) @(negedge clk);
      chk("t5_sb_empty", sb.size(), 0);

      // 6: RD_LATENCY=1 instance, back-to-back reads every 3 cycles
      c_req2 = 1;
      #1;
      for (int k = 0; k < 10; k++) begin
         chk("t6_gnt", {31'd0, c_gnt2}, (k % 3 == 0) ? 32'd1 : 32'd0);
         chk("t6_rvalid", {31'd0, c_rvalid2}, (k >= 3 && k % 3 == 0) ? 32'd1 : 32'd0);
         if (k >= 3 && k % 3 == 0) chk("t6_rdata", c_rdata2, 32'hC0DE0020);
         @(negedge clk); #1;
      end
      c_req2 = 0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
